// File: rtl/replay_accumulator_pkg.sv
//------------------------------------------------------------------------------
// Module : replay_accumulator_pkg
// Brief  : Shared types and helpers for the replay accumulator.
//          acc_width() gives the default accumulator width, which is wide
//          enough to hold REP summed W-bit items without overflow.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package replay_accumulator_pkg;

  // Pipeline-stage flags that travel with an item from S0 to S1.
  typedef struct packed {
    logic first;    // item belongs to repetition 0: ignore stored partial sum
    logic fin_rep;  // item belongs to the final repetition: emit, don't store
    logic lastpos;  // item sits at position LEN-1
  } s1_flags_t;

  function automatic int acc_width(input int w, input int rep);
    return w + $clog2(rep);
  endfunction

endpackage

`default_nettype wire

// File: rtl/replay_accumulator_if.sv
//------------------------------------------------------------------------------
// Module : replay_accumulator_if
// Brief  : Input and output streams of the replay accumulator.
//          Input : idat/ilast/ifin/ivld (producer) and irdy (consumer).
//          Output: odat/olast/ovld (accumulator) and ordy (sink).
//          slave  = accumulator side, master = environment side.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface replay_accumulator_if #(
  parameter int W  = 8,
  parameter int WA = 8
);
  logic [W-1:0]  idat;
  logic          ilast;
  logic          ifin;
  logic          ivld;
  logic          irdy;
  logic [WA-1:0] odat;
  logic          olast;
  logic          ovld;
  logic          ordy;

  modport slave (
    input  idat, ilast, ifin, ivld, ordy,
    output irdy, odat, olast, ovld
  );

  modport master (
    output idat, ilast, ifin, ivld, ordy,
    input  irdy, odat, olast, ovld
  );
endinterface

`default_nettype wire

// File: rtl/replay_accumulator_seq_counter.sv
//------------------------------------------------------------------------------
// Module : seq_counter
// Brief  : Wrapping 0..N-1 counter with a registered "at N-1" flag.
//          clk, rst   : clock, synchronous active-high reset
//          clr_i      : return to 0 (priority over en_i)
//          en_i       : advance by one, wrapping after N-1
//          cnt_o      : current count
//          last_o     : count == N-1 (registered, no compare on the output path)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_counter #(
  parameter int N  = 2,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          clr_i,
  input  wire logic          en_i,
  output logic [CW-1:0]      cnt_o,
  output logic               last_o
);

  localparam logic [CW-1:0] C_MAX = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (clr_i) begin
      cnt_d  = '0;
      last_d = (N == 1);
    end else if (en_i) begin
      if (last_q) begin
        cnt_d  = '0;
        last_d = (N == 1);
      end else begin
        cnt_d  = cnt_q + 1'b1;
        last_d = ((cnt_q + 1'b1) == C_MAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= (N == 1);
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = last_q;

endmodule

`default_nettype wire

// File: rtl/replay_accumulator.sv
//------------------------------------------------------------------------------
// Module : replay_accumulator
// Brief  : Collapses REP back-to-back repetitions of a LEN-item sequence into
//          one LEN-item vector of per-position sums.
//          clk, rst : clock, synchronous active-high reset
//          bus      : slave side of the input/output streams
//          err      : sticky flag, set when ilast/ifin disagree with the
//                     internal position/repetition counters
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module replay_accumulator
  import replay_accumulator_pkg::*;
#(
  parameter int LEN    = 1,
  parameter int REP    = 1,
  parameter int W      = 8,
  parameter int WA     = acc_width(W, REP),
  parameter int SIGNED = 1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  replay_accumulator_if.slave  bus,
  output logic                 err
);

  localparam int PW    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int RW    = (REP > 1) ? $clog2(REP) : 1;
  // Depth rounded up to a power of two so the position counter indexes the
  // array without a width mismatch; entries >= LEN are never addressed.
  localparam int DEPTH = 1 << PW;

  if (LEN < 1) begin : g_bad_len
    $error("replay_accumulator: LEN must be at least 1");
  end
  if (REP < 1) begin : g_bad_rep
    $error("replay_accumulator: REP must be at least 1");
  end
  if (WA < W) begin : g_bad_wa
    $error("replay_accumulator: WA must be at least W");
  end

  // ---------------------------------------------------------------- S0
  logic          accept;
  logic [PW-1:0] pos;
  logic          pos_last;
  logic [RW-1:0] rep;
  logic          rep_last;
  logic [WA-1:0] ext;

  assign accept = bus.ivld && bus.irdy;

  seq_counter #(.N(LEN), .CW(PW)) u_pos (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (1'b0),
    .en_i   (accept),
    .cnt_o  (pos),
    .last_o (pos_last)
  );

  seq_counter #(.N(REP), .CW(RW)) u_rep (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (1'b0),
    .en_i   (accept && pos_last),
    .cnt_o  (rep),
    .last_o (rep_last)
  );

  if (SIGNED != 0) begin : g_sext
    assign ext = WA'($signed(bus.idat));
  end else begin : g_zext
    assign ext = WA'(bus.idat);
  end

  // ---------------------------------------------------------------- S1
  logic [WA-1:0] mem_q [DEPTH];
  logic          s1_vld_q;
  logic [WA-1:0] s1_x_q, s1_x_d;
  logic [WA-1:0] s1_opnd_q, s1_opnd_d;
  logic [PW-1:0] s1_addr_q;
  s1_flags_t     s1_flg_q, s1_flg_d;
  logic [WA-1:0] sum;
  logic          s1_wr;
  logic          s1_out;
  logic          s1_blk;

  assign sum    = s1_x_q + (s1_flg_q.first ? '0 : s1_opnd_q);
  assign s1_wr  = s1_vld_q && !s1_flg_q.fin_rep;
  assign s1_out = s1_vld_q && s1_flg_q.fin_rep;
  // Only an emitting item can be blocked; partial-sum writes always retire.
  assign s1_blk = s1_out && bus.ovld && !bus.ordy;

  assign bus.irdy = !s1_vld_q || !s1_blk;

  // The operand is captured in S0, so the memory behaves like a synchronous
  // read. The only write that can be missed is the one S1 retires in this
  // same cycle, so that sum is forwarded when addresses match.
  always_comb begin
    s1_x_d         = ext;
    s1_flg_d.first   = (rep == '0);
    s1_flg_d.fin_rep = rep_last;
    s1_flg_d.lastpos = pos_last;
    if (s1_wr && (s1_addr_q == pos)) begin
      s1_opnd_d = sum;
    end else begin
      s1_opnd_d = mem_q[pos];
    end
  end

  always_ff @(posedge clk) begin
    if (s1_wr) begin
      mem_q[s1_addr_q] <= sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!s1_blk) begin
      s1_x_q    <= s1_x_d;
      s1_opnd_q <= s1_opnd_d;
      s1_addr_q <= pos;
      s1_flg_q  <= s1_flg_d;
    end
  end

  // ---------------------------------------------------------------- output
  logic          ovld_q;
  logic          olast_q;
  logic [WA-1:0] odat_q;
  logic          err_q, err_d;

  assign err_d = err_q || (accept && ((bus.ilast != pos_last) ||
                                      (bus.ifin != (pos_last && rep_last))));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      ovld_q   <= 1'b0;
      olast_q  <= 1'b0;
      odat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_d;
      if (!s1_blk) begin
        s1_vld_q <= accept;
      end
      // A fresh sum replaces a draining one and keeps ovld high.
      if (s1_out && !s1_blk) begin
        ovld_q  <= 1'b1;
        odat_q  <= sum;
        olast_q <= s1_flg_q.lastpos;
      end else if (bus.ordy) begin
        ovld_q <= 1'b0;
      end
    end
  end

  assign bus.ovld  = ovld_q;
  assign bus.odat  = odat_q;
  assign bus.olast = olast_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_replay_accumulator.sv
//------------------------------------------------------------------------------
// Module : tb_replay_accumulator
// Brief  : Self-checking bench for replay_accumulator. Four configurations are
//          instantiated side by side; a selector routes the shared stimulus to
//          one of them and muxes its outputs back. Expected sums come from a
//          per-position arithmetic model of whole frames.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_replay_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  int         sel;
  logic [7:0] t_idat;
  logic       t_ilast, t_ifin, t_ivld, t_ordy;

  int vecs = 0;
  int miss = 0;

  int cfg_len, cfg_rep, cfg_wa;
  bit cfg_signed;
  logic [7:0] stim[$];

  // A: LEN3 REP2 signed, B: LEN1 REP4 signed, C: LEN2 REP3 signed,
  // D: LEN1 REP2 unsigned with WA=W
  replay_accumulator_if #(.W(8), .WA(9))  ifa ();
  replay_accumulator_if #(.W(8), .WA(10)) ifb ();
  replay_accumulator_if #(.W(8), .WA(10)) ifc ();
  replay_accumulator_if #(.W(8), .WA(8))  ifd ();
  logic err_a, err_b, err_c, err_d;

  replay_accumulator #(.LEN(3), .REP(2), .W(8), .SIGNED(1)) u_a (
    .clk(clk), .rst(rst), .bus(ifa.slave), .err(err_a));
  replay_accumulator #(.LEN(1), .REP(4), .W(8), .SIGNED(1)) u_b (
    .clk(clk), .rst(rst), .bus(ifb.slave), .err(err_b));
  replay_accumulator #(.LEN(2), .REP(3), .W(8), .SIGNED(1)) u_c (
    .clk(clk), .rst(rst), .bus(ifc.slave), .err(err_c));
  replay_accumulator #(.LEN(1), .REP(2), .W(8), .WA(8), .SIGNED(0)) u_d (
    .clk(clk), .rst(rst), .bus(ifd.slave), .err(err_d));

  assign ifa.idat = t_idat; assign ifa.ilast = t_ilast; assign ifa.ifin = t_ifin;
  assign ifa.ivld = t_ivld && (sel == 0); assign ifa.ordy = (sel == 0) ? t_ordy : 1'b1;
  assign ifb.idat = t_idat; assign ifb.ilast = t_ilast; assign ifb.ifin = t_ifin;
  assign ifb.ivld = t_ivld && (sel == 1); assign ifb.ordy = (sel == 1) ? t_ordy : 1'b1;
  assign ifc.idat = t_idat; assign ifc.ilast = t_ilast; assign ifc.ifin = t_ifin;
  assign ifc.ivld = t_ivld && (sel == 2); assign ifc.ordy = (sel == 2) ? t_ordy : 1'b1;
  assign ifd.idat = t_idat; assign ifd.ilast = t_ilast; assign ifd.ifin = t_ifin;
  assign ifd.ivld = t_ivld && (sel == 3); assign ifd.ordy = (sel == 3) ? t_ordy : 1'b1;

  logic        m_irdy, m_olast, m_ovld, m_err;
  logic [15:0] m_odat;

  always_comb begin
    m_irdy = ifa.irdy; m_odat = 16'(ifa.odat); m_olast = ifa.olast; m_ovld = ifa.ovld; m_err = err_a;
    case (sel)
      1: begin m_irdy = ifb.irdy; m_odat = 16'(ifb.odat); m_olast = ifb.olast; m_ovld = ifb.ovld; m_err = err_b; end
      2: begin m_irdy = ifc.irdy; m_odat = 16'(ifc.odat); m_olast = ifc.olast; m_ovld = ifc.ovld; m_err = err_c; end
      3: begin m_irdy = ifd.irdy; m_odat = 16'(ifd.odat); m_olast = ifd.olast; m_ovld = ifd.ovld; m_err = err_d; end
      default: ;
    endcase
  end

  task automatic select_dut(input int k);
    sel = k;
    case (k)
      0:       begin cfg_len = 3; cfg_rep = 2; cfg_wa = 9;  cfg_signed = 1; end
      1:       begin cfg_len = 1; cfg_rep = 4; cfg_wa = 10; cfg_signed = 1; end
      2:       begin cfg_len = 2; cfg_rep = 3; cfg_wa = 10; cfg_signed = 1; end
      default: begin cfg_len = 1; cfg_rep = 2; cfg_wa = 8;  cfg_signed = 0; end
    endcase
  endtask

  function automatic longint ext(input logic [7:0] x);
    if (cfg_signed) return longint'($signed(x));
    return longint'(x);
  endfunction

  // Leaves the bench 1 time unit after a rising edge.
  task automatic do_reset(input bit check);
    rst = 1'b1; t_ivld = 1'b0; t_ordy = 1'b1; t_ilast = 1'b0; t_ifin = 1'b0; t_idat = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    if (check) begin
      @(negedge clk);
      vecs++; if (m_ovld !== 1'b0)  begin miss++; $display("FAIL reset_ovld: got %b want 0", m_ovld); end
      vecs++; if (m_olast !== 1'b0) begin miss++; $display("FAIL reset_olast: got %b want 0", m_olast); end
      vecs++; if (m_odat !== 16'd0) begin miss++; $display("FAIL reset_odat: got %0d want 0", m_odat); end
      vecs++; if (m_err !== 1'b0)   begin miss++; $display("FAIL reset_err: got %b want 0", m_err); end
      vecs++; if (m_irdy !== 1'b1)  begin miss++; $display("FAIL reset_irdy: got %b want 1", m_irdy); end
      @(posedge clk); #1;
    end
  endtask

  // Streams stim[] into the selected DUT. ordy_mode: 0 always ready,
  // 1 toggling, 2 random. gaps!=0 inserts random idle input cycles.
  // bad_idx names an item whose ilast is inverted (-1: none).
  task automatic run_stream(input int ordy_mode, input int gaps, input int bad_idx,
                            input string tag, output int drops);
    longint exp_q[$];
    bit     expl_q[$];
    int     acc_cyc[$];
    int     n, frame, idx, got, cyc, fin_i, limit;
    longint mask, s;
    bit     err_exp, prev_stall, prev_last;
    logic [15:0] prev_dat;

    n     = stim.size();
    frame = cfg_len * cfg_rep;
    mask  = (longint'(1) << cfg_wa) - 1;
    for (int f = 0; f < n / frame; f++) begin
      for (int p = 0; p < cfg_len; p++) begin
        s = 0;
        for (int r = 0; r < cfg_rep; r++) s += ext(stim[f*frame + r*cfg_len + p]);
        exp_q.push_back(s & mask);
        expl_q.push_back(p == cfg_len - 1);
      end
    end

    idx = 0; got = 0; cyc = 0; drops = 0; err_exp = 0;
    prev_stall = 0; prev_last = 0; prev_dat = '0;
    limit = n * 10 + 60;
    while (1) begin
      if (idx < n && (gaps == 0 || $urandom_range(0, 3) != 0)) begin
        t_ivld  = 1'b1;
        t_idat  = stim[idx];
        t_ilast = logic'((idx % cfg_len) == cfg_len - 1) ^ logic'(idx == bad_idx);
        t_ifin  = logic'((idx % frame) == frame - 1);
      end else begin
        t_ivld = 1'b0; t_ilast = 1'b0; t_ifin = 1'b0; t_idat = '0;
      end
      case (ordy_mode)
        0:       t_ordy = 1'b1;
        1:       t_ordy = logic'(cyc % 2 == 0);
        default: t_ordy = logic'($urandom_range(0, 1));
      endcase

      @(negedge clk);
      vecs++;
      if (m_err !== err_exp) begin
        miss++; $display("FAIL %s err cyc %0d: got %b want %b", tag, cyc, m_err, err_exp);
      end
      if (prev_stall) begin
        vecs++;
        if (m_ovld !== 1'b1 || m_odat !== prev_dat || m_olast !== prev_last) begin
          miss++;
          $display("FAIL %s hold cyc %0d: got v%b d%0d l%b want v1 d%0d l%b",
                   tag, cyc, m_ovld, m_odat, m_olast, prev_dat, prev_last);
        end
      end
      if (m_ovld && t_ordy) begin
        vecs++;
        if (got >= exp_q.size()) begin
          miss++; $display("FAIL %s extra output: got %0d want none", tag, m_odat);
        end else begin
          if ((longint'(m_odat) & mask) !== exp_q[got] || m_olast !== expl_q[got]) begin
            miss++;
            $display("FAIL %s odat[%0d]: got %0d last %b want %0d last %b",
                     tag, got, m_odat, m_olast, exp_q[got], expl_q[got]);
          end
          if (ordy_mode == 0) begin
            fin_i = (got / cfg_len) * frame + (cfg_rep - 1) * cfg_len + (got % cfg_len);
            vecs++;
            if (cyc != acc_cyc[fin_i] + 2) begin
              miss++;
              $display("FAIL %s latency[%0d]: got cycle %0d want %0d",
                       tag, got, cyc, acc_cyc[fin_i] + 2);
            end
          end
        end
        got++;
      end
      if (t_ivld && m_irdy) begin
        acc_cyc.push_back(cyc);
        if (idx == bad_idx) err_exp = 1;
        idx++;
      end
      if (!m_irdy) drops++;
      prev_stall = m_ovld && !t_ordy;
      prev_dat   = m_odat;
      prev_last  = m_olast;

      @(posedge clk); #1;
      cyc++;
      if (idx == n && got >= exp_q.size()) break;
      if (cyc > limit) begin
        vecs++; miss++;
        $display("FAIL %s timeout: got %0d items %0d outputs want %0d items %0d outputs",
                 tag, idx, got, n, exp_q.size());
        break;
      end
    end

    t_ivld = 1'b0; t_ordy = 1'b1; t_ilast = 1'b0; t_ifin = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vecs++;
      if (m_ovld !== 1'b0) begin miss++; $display("FAIL %s idle ovld: got %b want 0", tag, m_ovld); end
      @(posedge clk); #1;
    end
  endtask

  task automatic load_seq(input int a, input int b, input int c, input int d,
                          input int e, input int f, input int cnt);
    int v[6];
    v = '{a, b, c, d, e, f};
    stim.delete();
    for (int i = 0; i < cnt; i++) stim.push_back(8'(v[i]));
  endtask

  task automatic test_reset();
    select_dut(0);
    do_reset(1);
  endtask

  task automatic test_basic();
    int d;
    select_dut(0); do_reset(0);
    load_seq(1, 2, 3, 4, 5, 6, 6);
    run_stream(0, 0, -1, "basic", d);
  endtask

  task automatic test_forwarding();
    int d;
    select_dut(1); do_reset(0);
    load_seq(10, 20, 30, 40, 0, 0, 4);
    run_stream(0, 0, -1, "fwd", d);
    vecs++;
    if (d != 0) begin miss++; $display("FAIL fwd irdy_drops: got %0d want 0", d); end
  endtask

  task automatic test_backpressure();
    int d;
    select_dut(2); do_reset(0);
    load_seq(-1, 5, -2, 6, -3, 7, 6);
    run_stream(1, 0, -1, "bp", d);
  endtask

  task automatic test_wrap();
    int d;
    select_dut(3); do_reset(0);
    load_seq(200, 100, 0, 0, 0, 0, 2);
    run_stream(0, 0, -1, "wrap", d);
  endtask

  task automatic test_framing_err();
    int d;
    select_dut(0); do_reset(0);
    load_seq(1, 2, 3, 4, 5, 6, 6);
    run_stream(0, 0, 1, "ferr", d);
    vecs++;
    if (m_err !== 1'b1) begin miss++; $display("FAIL ferr sticky: got %b want 1", m_err); end
  endtask

  task automatic test_reset_midframe();
    int d;
    select_dut(0); do_reset(0);
    for (int i = 0; i < 4; i++) begin
      t_ivld = 1'b1; t_idat = 8'(i + 1);
      t_ilast = logic'(i % 3 == 2); t_ifin = 1'b0; t_ordy = 1'b1;
      @(negedge clk);
      vecs++;
      if (m_ovld !== 1'b0 || m_irdy !== 1'b1) begin
        miss++; $display("FAIL abort item%0d: got ovld %b irdy %b want 0 1", i, m_ovld, m_irdy);
      end
      @(posedge clk); #1;
    end
    t_ivld = 1'b0; t_ilast = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vecs++;
    if (m_ovld !== 1'b0 || m_err !== 1'b0) begin
      miss++; $display("FAIL abort post_reset: got ovld %b err %b want 0 0", m_ovld, m_err);
    end
    @(posedge clk); #1;
    load_seq(1, 2, 3, 4, 5, 6, 6);
    run_stream(0, 0, -1, "abort", d);
  endtask

  task automatic test_random();
    int d, frame;
    for (int k = 0; k < 4; k++) begin
      select_dut(k); do_reset(0);
      frame = cfg_len * cfg_rep;
      stim.delete();
      for (int i = 0; i < 3 * frame; i++) stim.push_back(8'($urandom_range(0, 255)));
      run_stream(2, 1, -1, "rand_bp", d);
      stim.delete();
      for (int i = 0; i < 2 * frame; i++) stim.push_back(8'($urandom_range(0, 255)));
      run_stream(0, 0, -1, "rand_b2b", d);
    end
  endtask

  initial begin
    sel = 0; rst = 1'b1;
    t_idat = '0; t_ilast = 1'b0; t_ifin = 1'b0; t_ivld = 1'b0; t_ordy = 1'b1;
    test_reset();
    test_basic();
    test_forwarding();
    test_backpressure();
    test_wrap();
    test_framing_err();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

`default_nettype wire
